// File: rtl/instr_encode_loader.sv
// instr_encode_loader
//   Packs one instruction per valid/ready handshake from separate fields into
//   a 32-bit ARM word and writes the words into consecutive instruction-memory
//   locations, starting at base_addr and wrapping modulo 2^ADDR_WIDTH.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   start             begin a load run (only looked at while idle)
//   base_addr         first word address of the run
//   num_words         number of legal instructions to write (0 = empty run)
//   in_valid/in_ready field-bundle handshake; in_ready is high only in LOAD
//   fmt ... branchImmediate
//                     instruction fields; fmt selects which of them are used
//   mem_we/mem_addr/mem_wdata
//                     registered one-cycle instruction-memory write port
//   busy              high whenever a run is in progress
//   done              one-cycle pulse at the end of a run
//   error             sticky flag, set when a bundle with fmt=11 is consumed

module instr_encode_loader #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   num_words,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            fmt,
  input  logic [3:0]            cond,
  input  logic [3:0]            opcode,
  input  logic                  sBit,
  input  logic                  immBit,
  input  logic [3:0]            rn,
  input  logic [3:0]            rd,
  input  logic [3:0]            rm,
  input  logic [7:0]            rm_shift,
  input  logic [7:0]            immediateVal,
  input  logic [3:0]            rotateVal,
  input  logic [11:0]           immediateOffset,
  input  logic                  prePostAddOffset,
  input  logic                  upDownOffset,
  input  logic                  byteOrWord,
  input  logic                  writeBack,
  input  logic                  loadStore,
  input  logic                  linkBit,
  input  logic [23:0]           branchImmediate,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WRITE,
    DONE
  } state_t;

  localparam logic [1:0] FMT_DP     = 2'b00;
  localparam logic [1:0] FMT_SDT    = 2'b01;
  localparam logic [1:0] FMT_BRANCH = 2'b10;

  state_t              state;
  logic [ADDR_WIDTH:0] remaining;
  logic [31:0]         encoded;
  logic [11:0]         dp_low12;
  logic [11:0]         sdt_low12;

  assign in_ready = (state == LOAD);

  // The meaning of immBit is inverted between the two formats: for data
  // processing it selects the rotated immediate, for load/store it selects
  // the shifted-register offset.
  always_comb begin
    dp_low12  = immBit ? {rotateVal, immediateVal} : {rm_shift, rm};
    sdt_low12 = immBit ? {rm_shift, rm} : immediateOffset;
    encoded   = 32'h0;
    case (fmt)
      FMT_DP:     encoded = {cond, 2'b00, immBit, opcode, sBit, rn, rd, dp_low12};
      FMT_SDT:    encoded = {cond, 2'b01, immBit, prePostAddOffset, upDownOffset,
                             byteOrWord, writeBack, loadStore, rn, rd, sdt_low12};
      FMT_BRANCH: encoded = {cond, 3'b101, linkBit, branchImmediate};
      default:    encoded = 32'h0;
    endcase
  end

  // Run control. An illegal bundle is swallowed without touching the word
  // count, so the run still ends only after num_words real writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'h0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (num_words != '0) begin
              mem_addr  <= base_addr;
              remaining <= num_words;
              error     <= 1'b0;
              state     <= LOAD;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        LOAD: begin
          if (in_valid) begin
            if (fmt == 2'b11) begin
              error <= 1'b1;
            end else begin
              mem_wdata <= encoded;
              mem_we    <= 1'b1;
              state     <= WRITE;
            end
          end
        end
        WRITE: begin
          mem_we    <= 1'b0;
          mem_addr  <= mem_addr + ADDR_WIDTH'(1);
          remaining <= remaining - (ADDR_WIDTH+1)'(1);
          if (remaining == (ADDR_WIDTH+1)'(1)) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= LOAD;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encode_loader.sv
// tb_instr_encode_loader
//   Directed bench for instr_encode_loader. Expected writes (address, word)
//   are queued when a bundle is offered and popped by a write monitor that
//   watches mem_we on the falling clock edge.

module tb_instr_encode_loader;

  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   num_words;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    fmt;
  logic [3:0]    cond, opcode, rn, rd, rm, rotateVal;
  logic          sBit, immBit;
  logic [7:0]    rm_shift, immediateVal;
  logic [11:0]   immediateOffset;
  logic          prePostAddOffset, upDownOffset, byteOrWord, writeBack, loadStore;
  logic          linkBit;
  logic [23:0]   branchImmediate;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy, done, error;

  int compared   = 0;
  int mismatched = 0;
  int writes     = 0;
  int writes_at_start;
  logic [AW+31:0] sb[$];

  instr_encode_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .num_words(num_words), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .cond(cond), .opcode(opcode), .sBit(sBit), .immBit(immBit),
    .rn(rn), .rd(rd), .rm(rm), .rm_shift(rm_shift),
    .immediateVal(immediateVal), .rotateVal(rotateVal),
    .immediateOffset(immediateOffset), .prePostAddOffset(prePostAddOffset),
    .upDownOffset(upDownOffset), .byteOrWord(byteOrWord),
    .writeBack(writeBack), .loadStore(loadStore), .linkBit(linkBit),
    .branchImmediate(branchImmediate), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      logic [AW+31:0] item;
      writes++;
      checkOutput("write_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        item = sb.pop_front();
        checkOutput("mem_addr", 32'(mem_addr), 32'(item[AW+31:32]));
        checkOutput("mem_wdata", mem_wdata, item[31:0]);
      end
    end
  end

  task automatic clearFields();
    fmt = 2'b00; cond = 4'h0; opcode = 4'h0; sBit = 1'b0; immBit = 1'b0;
    rn = 4'h0; rd = 4'h0; rm = 4'h0; rm_shift = 8'h0; immediateVal = 8'h0;
    rotateVal = 4'h0; immediateOffset = 12'h0; prePostAddOffset = 1'b0;
    upDownOffset = 1'b0; byteOrWord = 1'b0; writeBack = 1'b0; loadStore = 1'b0;
    linkBit = 1'b0; branchImmediate = 24'h0;
  endtask

  task automatic startRun(input logic [AW-1:0] base, input logic [AW:0] num);
    @(negedge clk);
    start = 1'b1; base_addr = base; num_words = num;
    writes_at_start = writes;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("busy_after_start", 32'(busy), 32'd1);
  endtask

  // Offers the current field bundle and waits (bounded) for the handshake.
  task automatic applyStimulus(input logic expect_write, input logic [AW-1:0] exp_addr,
                               input logic [31:0] exp_data);
    int waited = 0;
    if (expect_write) sb.push_back({exp_addr, exp_data});
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("ready_seen", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("we_latency", 32'(mem_we), 32'(expect_write));
    @(negedge clk);
  endtask

  task automatic waitDone(input int exp_writes);
    int waited = 0;
    logic seen = 1'b0;
    while (!seen && waited < 20) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
      waited++;
    end
    checkOutput("done_pulse", 32'(seen), 32'd1);
    checkOutput("write_count", 32'(writes - writes_at_start), 32'(exp_writes));
    @(negedge clk);
    checkOutput("done_single_cycle", 32'(done), 32'd0);
    checkOutput("busy_cleared", 32'(busy), 32'd0);
  endtask

  task automatic checkResetValues();
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_error", 32'(error), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; num_words = '0; in_valid = 1'b0;
    clearFields();
    repeat (3) @(posedge clk);
    #1;
    checkResetValues();
    reset = 1'b0;

    // Single data-processing immediate word at address 0.
    $display("[TB] single word run");
    startRun(6'd0, 7'd1);
    clearFields();
    fmt = 2'b00; cond = 4'hE; immBit = 1'b1; opcode = 4'h4; rn = 4'hD; rd = 4'hB;
    immediateVal = 8'h04;
    applyStimulus(1'b1, 6'd0, 32'hE28DB004);
    waitDone(1);

    // Three mixed formats from address 5, with a start pulse mid-run.
    $display("[TB] three word run");
    startRun(6'd5, 7'd3);
    clearFields();
    fmt = 2'b01; cond = 4'hE; prePostAddOffset = 1'b1; upDownOffset = 1'b1;
    loadStore = 1'b1; rn = 4'hF; immediateOffset = 12'h014;
    applyStimulus(1'b1, 6'd5, 32'hE59F0014);
    start = 1'b1; base_addr = 6'd20; num_words = 7'd0;
    repeat (2) @(negedge clk);
    start = 1'b0;
    checkOutput("busy_start_ignored", 32'(busy), 32'd1);
    clearFields();
    fmt = 2'b10; cond = 4'hE; linkBit = 1'b1; branchImmediate = 24'hFFFFFE;
    applyStimulus(1'b1, 6'd6, 32'hEBFFFFFE);
    clearFields();
    fmt = 2'b00; cond = 4'hE; immBit = 1'b1; opcode = 4'hD; rd = 4'h3;
    applyStimulus(1'b1, 6'd7, 32'hE3A03000);
    waitDone(3);

    // Address wrap; register-form DP and register-offset load/store.
    $display("[TB] wrap run");
    startRun(6'd63, 7'd2);
    clearFields();
    fmt = 2'b00; opcode = 4'h2; sBit = 1'b1; rn = 4'h1; rd = 4'h2;
    rm_shift = 8'h40; rm = 4'h3; immediateVal = 8'hFF; rotateVal = 4'hF;
    applyStimulus(1'b1, 6'd63, 32'h00512403);
    clearFields();
    fmt = 2'b01; cond = 4'h1; immBit = 1'b1; upDownOffset = 1'b1; byteOrWord = 1'b1;
    rn = 4'h4; rd = 4'h5; rm = 4'h6; immediateOffset = 12'hABC;
    applyStimulus(1'b1, 6'd0, 32'h16C45006);
    waitDone(2);

    // Illegal format is dropped, flags error, and does not consume the count.
    $display("[TB] illegal format run");
    startRun(6'd12, 7'd1);
    clearFields();
    fmt = 2'b11; cond = 4'hE;
    applyStimulus(1'b0, 6'd0, 32'h0);
    checkOutput("error_set", 32'(error), 32'd1);
    checkOutput("still_ready", 32'(in_ready), 32'd1);
    clearFields();
    fmt = 2'b10; cond = 4'hA; branchImmediate = 24'h000010;
    applyStimulus(1'b1, 6'd12, 32'hAA000010);
    waitDone(1);
    repeat (3) @(negedge clk);
    checkOutput("error_sticky", 32'(error), 32'd1);
    startRun(6'd30, 7'd1);
    checkOutput("error_cleared", 32'(error), 32'd0);
    clearFields();
    fmt = 2'b00; cond = 4'hE; immBit = 1'b1; opcode = 4'hD; rd = 4'h1;
    rotateVal = 4'h2; immediateVal = 8'h80;
    applyStimulus(1'b1, 6'd30, 32'hE3A01280);
    waitDone(1);

    // Empty run.
    $display("[TB] empty run");
    startRun(6'd9, 7'd0);
    waitDone(0);

    // Reset during the write of word 2 of a 4-word run.
    $display("[TB] reset abort");
    startRun(6'd40, 7'd4);
    clearFields();
    fmt = 2'b00; cond = 4'hE; immBit = 1'b1; opcode = 4'hD; rd = 4'h2;
    applyStimulus(1'b1, 6'd40, 32'hE3A02000);
    sb.push_back({6'd41, 32'hE3A02000});
    in_valid = 1'b1;
    for (int i = 0; i < 20 && in_ready !== 1'b1; i++) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    checkOutput("write2_we", 32'(mem_we), 32'd1);
    @(posedge clk); #1;
    checkResetValues();
    reset = 1'b0;
    writes_at_start = writes;
    repeat (6) @(negedge clk);
    in_valid = 1'b0;
    checkOutput("no_write_after_reset", 32'(writes - writes_at_start), 32'd0);
    checkOutput("idle_after_reset", 32'(busy), 32'd0);
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
